// File: rtl/calc_disp_pkg.sv
// -----------------------------------------------------------------------------
// calc_disp_pkg
// Shared constants, FSM state encoding and a digit-select helper for the
// multiplexed 10-digit display scan controller.
//   BLANK_CODE : BCD code that the controller treats as "digit not lit"
//   NUM_DIGITS : number of display slots
//   DEC_W      : width of a packed ten-digit BCD word
// -----------------------------------------------------------------------------
package calc_disp_pkg;

    localparam logic [3:0] BLANK_CODE = 4'ha;
    localparam int         NUM_DIGITS = 32'sd10;
    localparam int         DEC_W      = 32'sd4 * NUM_DIGITS;
    localparam logic [3:0] LAST_SLOT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2
    } disp_state_e;

    // Returns BCD digit number idx (0 = rightmost) of a packed ten-digit word.
    function automatic logic [3:0] digit_at(input logic [DEC_W-1:0] v,
                                            input logic [3:0]       idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl_if
// Valid/ready result-transfer bundle between a result producer and the
// display scan controller.
//   in_valid : producer offers a new result
//   in_ready : controller can accept a result
//   in_dec   : ten packed BCD digits, digit 9 in [39:36]
//   in_err   : result is an error/overflow, qualified by in_valid
// Modports: master = producer side, slave = controller side.
// -----------------------------------------------------------------------------
interface disp_scan_ctrl_if;
    import calc_disp_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DEC_W-1:0] in_dec;
    logic             in_err;

    modport master (output in_valid, output in_dec, output in_err, input  in_ready);
    modport slave  (input  in_valid, input  in_dec, input  in_err, output in_ready);

endinterface

// File: rtl/digit_shift.sv
// -----------------------------------------------------------------------------
// digit_shift
// Leading-zero shifter: moves the most significant non-zero digit to slot 9
// and fills the vacated low slots with BLANK_CODE. Digit 0 is never counted
// as a leading zero, so an all-zero input becomes a single "0" in slot 9.
//   dec_i : packed BCD input, digit 9 in [39:36]
//   dig_o : left-justified, blank-padded digits
// -----------------------------------------------------------------------------
module digit_shift
    import calc_disp_pkg::*;
(
    input  logic [DEC_W-1:0] dec_i,
    output logic [DEC_W-1:0] dig_o
);

    localparam logic [DEC_W-1:0] BLANK_FILL = {NUM_DIGITS{BLANK_CODE}};
    localparam logic [DEC_W-1:0] ALL_ONES   = {DEC_W{1'b1}};

    logic [3:0] lz_s;
    logic       found_s;
    logic [5:0] sh_s;

    // Count zero digits from the left, stopping at digit 1.
    always_comb begin
        lz_s    = 4'd0;
        found_s = 1'b0;
        for (int i = NUM_DIGITS - 32'sd1; i >= 32'sd1; i--) begin
            if (!found_s && (dec_i[4*i +: 4] == 4'd0)) begin
                lz_s = lz_s + 4'd1;
            end else begin
                found_s = 1'b1;
            end
        end
    end

    assign sh_s = {lz_s, 2'b00};

    // Shift left by whole digits; vacated low nibbles become blank codes.
    always_comb begin
        dig_o = (dec_i << sh_s) | (BLANK_FILL & ~(ALL_ONES << sh_s));
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
// Accepts a ten-digit BCD result over a valid/ready bundle, left-justifies it
// with digit_shift and time-multiplexes it onto a 10-slot display, slot 9
// (leftmost) first, REFRESH_DIV clock cycles per slot.
// Ports:
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-low reset
//   clear      : synchronous request to blank the display and go IDLE
//   bus        : disp_scan_ctrl_if.slave (in_valid/in_ready/in_dec/in_err)
//   seg_code   : registered BCD code of the active slot, 4'ha = blank
//   an_n       : registered active-low one-hot slot enable, bit 9 leftmost
//   frame_tick : one-cycle pulse at the end of every full 10-slot scan
// Parameters: REFRESH_DIV (>=2) cycles per slot, BLINK_DIV (>=1) frames per
// blink half-period.
// Optional build macro DISP_BLINK_EN: an error result blinks the display,
// alternating BLINK_DIV visible frames with BLINK_DIV dark frames. Without it
// in_err is ignored and BLINK_DIV has no effect.
// -----------------------------------------------------------------------------
module disp_scan_ctrl
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 32'sd100000,
    parameter int BLINK_DIV   = 32'sd50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    disp_scan_ctrl_if.slave       bus,
    output logic [3:0]            seg_code,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_tick
);

    localparam int                    CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(REFRESH_DIV - 32'sd1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(32'd1);
    localparam logic [DEC_W-1:0]      BLANK_FILL = {NUM_DIGITS{BLANK_CODE}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(32'd1);

    disp_state_e           state_q, state_d;
    logic [DEC_W-1:0]      dec_q, dec_d;
    logic [DEC_W-1:0]      digits_q, digits_d;
    logic [DEC_W-1:0]      shifted_s;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            slot_q, slot_d;
    logic [3:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;
    logic                  rdy_q, rdy_d;
    logic                  xfer_s;
    logic                  wrap_s;
    logic                  scanning_s;
    logic                  dark_s;
    logic [3:0]            cur_code_s;

    // clear wins over a simultaneous handshake, so no transfer completes then
    assign xfer_s     = bus.in_valid & rdy_q & ~clear;
    assign wrap_s     = (state_q == SCAN) && (cnt_q == CNT_MAX);
    // only show digits when this cycle stays in SCAN; leaving blanks at once
    assign scanning_s = (state_q == SCAN) && (state_d == SCAN);
    assign cur_code_s = digit_at(digits_q, slot_q);

    assign bus.in_ready = rdy_q;
    assign seg_code     = seg_q;
    assign an_n         = an_q;
    assign frame_tick   = tick_q;

    digit_shift u_digit_shift (
        .dec_i (dec_q),
        .dig_o (shifted_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = xfer_s ? LOAD : IDLE;
                LOAD:    state_d = SCAN;
                SCAN:    state_d = xfer_s ? LOAD : SCAN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: captured result, shifted digits, slot timing.
    always_comb begin
        dec_d    = dec_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        tick_d   = 1'b0;
        if (clear) begin
            digits_d = BLANK_FILL;
            cnt_d    = '0;
            slot_d   = 4'd0;
        end else if (xfer_s) begin
            dec_d = bus.in_dec;
        end else if (state_q == LOAD) begin
            digits_d = shifted_s;
            slot_d   = LAST_SLOT;
            cnt_d    = '0;
        end else if (state_q == SCAN) begin
            if (wrap_s) begin
                cnt_d = '0;
                if (slot_q == 4'd0) begin
                    slot_d = LAST_SLOT;
                    tick_d = 1'b1;
                end else begin
                    slot_d = slot_q - 4'd1;
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int               BLK_W   = (BLINK_DIV > 32'sd1) ? $clog2(BLINK_DIV) : 32'sd1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 32'sd1);
    localparam logic [BLK_W-1:0] BLK_ONE = BLK_W'(32'd1);

    logic             err_q, err_d;
    logic [BLK_W-1:0] bcnt_q, bcnt_d;
    logic             phase_q, phase_d;

    // Blink bookkeeping: latched error flag and frame-counted dark phase.
    always_comb begin
        err_d   = xfer_s ? bus.in_err : err_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (clear || (state_q == LOAD)) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (tick_d) begin
            if (bcnt_q == BLK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BLK_ONE;
            end
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q   <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            err_q   <= err_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign dark_s = err_q & phase_q;
`else
    logic unused_cfg_s;

    assign dark_s       = 1'b0;
    assign unused_cfg_s = ^{1'b0, bus.in_err, BLINK_DIV[0]};
`endif

    // FSM outputs: ready flag and next display drive, registered below.
    always_comb begin
        rdy_d = (state_d != LOAD);
        if (scanning_s) begin
            seg_d = cur_code_s;
            if ((cur_code_s != BLANK_CODE) && !dark_s) begin
                an_d = ~(AN_ONE << slot_q);
            end else begin
                an_d = AN_OFF;
            end
        end else begin
            seg_d = BLANK_CODE;
            an_d  = AN_OFF;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_q    <= '0;
            digits_q <= BLANK_FILL;
            cnt_q    <= '0;
            slot_q   <= 4'd0;
            seg_q    <= BLANK_CODE;
            an_q     <= AN_OFF;
            tick_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            dec_q    <= dec_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
            rdy_q    <= rdy_d;
        end
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit slot is driven (min 2).
REQ-002 SHALL have parameter BLINK_DIV, default 50, scan frames per blink half-period (min 1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous request to blank the display and return to IDLE.
REQ-006 SHALL have port in_valid  input  1  new result offered.
REQ-007 SHALL have port in_ready  output  1  controller can accept a result.
REQ-008 SHALL have port in_dec  input  40  ten packed BCD digits, digit 9 in [39:36].
REQ-009 SHALL have port in_err  input  1  result is an error/overflow, sampled with in_dec.
REQ-010 SHALL have port seg_code  output  4  BCD code of the active slot; 4'ha means blank.
REQ-011 SHALL have port an_n  output  10  active-low one-hot slot enable, bit 9 is leftmost.
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse at the end of each full 10-slot scan.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD and SCAN.
REQ-014 In IDLE, SHALL drive an_n=10'h3FF, seg_code=4'ha and in_ready=1.
REQ-015 SHALL complete a transfer on a cycle where in_valid and in_ready are both 1, registering in_dec and in_err, then enter LOAD.
REQ-016 In LOAD, SHALL hold in_ready=0 for exactly one cycle, register the left-justified, blank-padded digits from the leading-zero shifter, then enter SCAN.
REQ-017 On entering SCAN, SHALL set slot index 9, clear the refresh counter and clear the blink phase.
REQ-018 In SCAN, SHALL hold in_ready=1; a new transfer SHALL abort the scan and enter LOAD.
REQ-019 In SCAN, SHALL increment the refresh counter every cycle from 0 to REFRESH_DIV-1, then wrap to 0 and decrement the slot index, wrapping 0 to 9.
REQ-020 SHALL pulse frame_tick for one cycle on the cycle the slot index wraps from 0 to 9.
REQ-021 SHALL drive seg_code from the registered digit of the current slot and an_n low at that slot only.
REQ-022 SHALL hold an_n high for any slot whose code is 4'ha, while still spending REFRESH_DIV cycles on that slot.
REQ-023 SHALL register seg_code and an_n, giving one cycle of latency from index or counter change to output.
REQ-024 When clear is 1, SHALL enter IDLE on the next edge from any state and SHALL NOT complete a transfer that cycle.
REQ-025 SHALL display input 0 as a single "0" in slot 9 with the other slots blank.

Reset
REQ-026 While rst=0, SHALL asynchronously force state IDLE, an_n=10'h3FF, seg_code=4'ha, in_ready=0, frame_tick=0, all counters 0, latched error 0 and stored digits all 4'ha.
REQ-027 SHALL assert in_ready on the first rising clk edge after rst deasserts.
REQ-028 If rst asserts mid-scan or in LOAD, SHALL discard the pending value.

Configuration
REQ-029 With macro DISP_BLINK_EN defined, when the latched error is 1, SHALL force an_n=10'h3FF during alternate BLINK_DIV-frame periods, starting visible, counted by frame_tick.
REQ-030 Without DISP_BLINK_EN, SHALL ignore in_err, omit the blink counter, and leave the BLINK_DIV parameter unused.

Structure
REQ-031 SHALL place BLANK_CODE (4'ha), NUM_DIGITS (10) and the FSM state enumeration in shared package calc_disp_pkg.
REQ-032 SHALL instantiate the existing leading-zero shifter, digit_shift, as the only sub-module, fed from the registered in_dec.

Verification
REQ-033 Reset, then release: SHALL show an_n=3FF and seg_code=a during reset, and in_ready=1 on the first edge after release.
REQ-034 With REFRESH_DIV=4, load 0x0000010234: SHALL scan slots 9..5 showing 1,0,2,3,4, each for 4 cycles with the matching an_n bit low, then keep an_n=3FF for 20 cycles on slots 4..0, then assert frame_tick.
REQ-035 Load 0x0000000000: SHALL show only slot 9 with code 0 and all other slots dark.
REQ-036 Load 0x0000000005, then mid-scan load 0x9999999999: SHALL show LOAD for one cycle, restart at slot 9, and show 9 in all ten slots.
REQ-037 Assert clear together with in_valid: SHALL complete no transfer and enter IDLE with an_n=3FF on the next edge.
REQ-038 With DISP_BLINK_EN, BLINK_DIV=1 and in_err=1: SHALL show the display lit for frame 1, dark (an_n=3FF) for frame 2, and lit for frame 3.
